// File: rtl/fu_resp_buffer_pkg.sv
// ============================================================================
// fu_resp_buffer_pkg -- shared result-bundle type and valid-bit position. Rev 1.0
// ============================================================================
`default_nettype none

package fu_resp_buffer_pkg;

  localparam int OPID_VLD = 15;

  typedef struct packed {
    logic [15:0] opid;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        exc;
  } exe_bundle_t;

  function automatic logic bundle_valid(input exe_bundle_t b);
    return b.opid[OPID_VLD];
  endfunction

endpackage

`default_nettype wire

// File: rtl/fu_resp_buffer_if.sv
// ============================================================================
// fu_resp_buffer_if -- enqueue / response / claim bundle of one FU result queue. Rev 1.0
// ============================================================================
`default_nettype none

interface fu_resp_buffer_if
  import fu_resp_buffer_pkg::*;
#(
  parameter int EWD   = 2,
  parameter int DEPTH = 8
);

  localparam int CW = $clog2(DEPTH + 1);

  logic                    flush;
  exe_bundle_t [EWD-1:0]   enq;
  logic                    enq_ready;
  exe_bundle_t [EWD-1:0]   fu_resp;
  logic        [EWD-1:0]   fu_claim;
  logic        [CW-1:0]    count;

  modport master (
    output flush, enq, fu_claim,
    input  enq_ready, fu_resp, count
  );

  modport slave (
    input  flush, enq, fu_claim,
    output enq_ready, fu_resp, count
  );

endinterface

`default_nettype wire

// File: rtl/fu_resp_buffer_lane_compact.sv
// ============================================================================
// lane_compact -- packs sparse valid lanes densely in ascending order, plus popcount. Rev 1.0
// ============================================================================
`default_nettype none

module lane_compact
  import fu_resp_buffer_pkg::*;
#(
  parameter int EWD = 2
) (
  input  exe_bundle_t [EWD-1:0]         lanes,
  output exe_bundle_t [EWD-1:0]         dense,
  output logic [$clog2(EWD+1)-1:0]      cnt
);

  localparam int LW = $clog2(EWD + 1);

  always_comb begin
    int pos;
    dense = '0;
    pos   = 0;
    for (int j = 0; j < EWD; j++) begin
      if (bundle_valid(lanes[j])) begin
        for (int k = 0; k < EWD; k++) begin
          if (k == pos) dense[k] = lanes[j];
        end
        pos = pos + 1;
      end
    end
    cnt = LW'(pos);
  end

endmodule

`default_nettype wire

// File: rtl/fu_resp_buffer.sv
// ============================================================================
// fu_resp_buffer -- FU result queue; oldest EWD entries shown, retired by prefix claim. Rev 1.0
// ============================================================================
`default_nettype none

module fu_resp_buffer
  import fu_resp_buffer_pkg::*;
#(
  parameter int EWD   = 2,
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  fu_resp_buffer_if.slave   bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = $clog2(EWD + 1);

  exe_bundle_t           r_mem [DEPTH];
  logic [AW-1:0]         r_head;
  logic [AW-1:0]         r_tail;
  logic [CW-1:0]         r_count;

  exe_bundle_t [EWD-1:0] w_dense;
  logic [LW-1:0]         w_enq_cnt;
  logic [LW-1:0]         w_acc_cnt;
  logic [LW-1:0]         w_ret_cnt;
  logic                  w_enq_ready;
  exe_bundle_t [EWD-1:0] w_resp;
  logic [EWD-1:0]        w_resp_vld;
  logic [AW-1:0]         w_ptr_diff;

  lane_compact #(.EWD(EWD)) u_compact (
    .lanes (bus.enq),
    .dense (w_dense),
    .cnt   (w_enq_cnt)
  );

  // Readiness looks only at registered occupancy; a same-cycle retire is not credited.
  assign w_enq_ready = (r_count <= CW'(DEPTH - EWD));
  assign w_acc_cnt   = w_enq_ready ? w_enq_cnt : '0;
  assign w_ptr_diff  = r_tail - r_head;

  always_comb begin
    w_resp     = '0;
    w_resp_vld = '0;
    for (int j = 0; j < EWD; j++) begin
      if (CW'(j) < r_count) begin
        w_resp[j]     = r_mem[r_head + AW'(j)];
        w_resp_vld[j] = bundle_valid(w_resp[j]);
      end
    end
  end

  // Retire only the unbroken run of claimed, valid lanes starting at lane 0.
  always_comb begin
    int   n;
    logic run;
    n   = 0;
    run = 1'b1;
    for (int j = 0; j < EWD; j++) begin
      run = run & bus.fu_claim[j] & w_resp_vld[j];
      if (run) n = n + 1;
    end
    w_ret_cnt = LW'(n);
  end

  always_ff @(posedge clk) begin
    if (!rst || bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      // Retired slots and free slots never overlap, so both writes can share a cycle.
      for (int k = 0; k < EWD; k++) begin
        if (LW'(k) < w_ret_cnt) r_mem[r_head + AW'(k)] <= '0;
        if (LW'(k) < w_acc_cnt) r_mem[r_tail + AW'(k)] <= w_dense[k];
      end
      r_head  <= r_head + AW'(w_ret_cnt);
      r_tail  <= r_tail + AW'(w_acc_cnt);
      r_count <= r_count + CW'(w_acc_cnt) - CW'(w_ret_cnt);
    end
  end

  assign bus.enq_ready = w_enq_ready;
  assign bus.fu_resp   = w_resp;
  assign bus.count     = r_count;

  always @(posedge clk) begin
    if (rst && !bus.flush) begin
      assert (w_enq_ready || (w_enq_cnt == '0))
        else $warning("fu_resp_buffer: enq while not ready, lanes dropped");
      assert ((bus.fu_claim & (bus.fu_claim + EWD'(1))) == '0)
        else $warning("fu_resp_buffer: non-prefix claim, only prefix retired");
    end
    if (rst) begin
      assert (r_count <= CW'(DEPTH));
      assert ((r_count == CW'(DEPTH)) || (r_count == CW'(w_ptr_diff)));
      assert ((w_resp_vld & (w_resp_vld + EWD'(1))) == '0);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fu_resp_buffer.sv
// ============================================================================
// tb_fu_resp_buffer -- directed + random stimulus against a queue model of the buffer. Rev 1.0
// ============================================================================
`default_nettype none

module tb_fu_resp_buffer;
  import fu_resp_buffer_pkg::*;

  localparam int EWD   = 2;
  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  bit   chk_en;

  exe_bundle_t mq[$];

  fu_resp_buffer_if #(.EWD(EWD), .DEPTH(DEPTH)) bus ();

  fu_resp_buffer #(.EWD(EWD), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a plain FIFO queue of accepted bundles.
  always @(posedge clk) begin : model
    int n;
    bit run;
    bit rdy;
    if (!rst_n || bus.flush) begin
      mq.delete();
    end else begin
      rdy = (DEPTH - mq.size()) >= EWD;
      n   = 0;
      run = 1'b1;
      for (int j = 0; j < EWD; j++) begin
        run = run && bus.fu_claim[j] && (j < mq.size());
        if (run) n++;
      end
      for (int j = 0; j < n; j++) void'(mq.pop_front());
      if (rdy) begin
        for (int j = 0; j < EWD; j++)
          if (bus.enq[j].opid[OPID_VLD]) mq.push_back(bus.enq[j]);
      end
    end
  end

  always @(negedge clk) begin : compare
    exe_bundle_t exp [EWD];
    bit ok;
    if (chk_en) begin
      ok = 1'b1;
      for (int j = 0; j < EWD; j++) begin
        exp[j] = (j < mq.size()) ? mq[j] : '0;
        if (bus.fu_resp[j] !== exp[j]) ok = 1'b0;
      end
      if (bus.count !== 4'(mq.size())) ok = 1'b0;
      if (bus.enq_ready !== ((DEPTH - mq.size()) >= EWD)) ok = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL model_cmp t=%0t count=%0d want %0d ready=%0b lane0=%h want %h lane1=%h want %h",
                 $time, bus.count, mq.size(), bus.enq_ready,
                 bus.fu_resp[0], exp[0], bus.fu_resp[1], exp[1]);
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic exe_bundle_t mk(input logic [15:0] opid);
    exe_bundle_t b;
    b        = '0;
    b.opid   = opid;
    b.result = {16'hA5A5, opid};
    b.rd     = opid[4:0];
    return b;
  endfunction

  task automatic idle();
    bus.enq      = '0;
    bus.fu_claim = '0;
    bus.flush    = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push2(input logic [15:0] op);
    bus.enq[0] = mk(op);
    bus.enq[1] = mk(op + 16'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(negedge clk);
    check("reset_count", bus.count, 0);
    check("reset_ready", bus.enq_ready, 1);
    check("reset_resp", bus.fu_resp, 0);
    rst_n = 1'b1;

    // Dense pair becomes visible the next cycle.
    push2(16'h8001);
    step(); idle();
    check("t1_lane0", bus.fu_resp[0].opid, 16'h8001);
    check("t1_lane1", bus.fu_resp[1].opid, 16'h8002);
    check("t1_count", bus.count, 2);

    // Sparse enqueue from empty.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    bus.enq[0] = mk(16'h0005);
    bus.enq[1] = mk(16'h8005);
    step(); idle();
    check("t2_lane0", bus.fu_resp[0].opid, 16'h8005);
    check("t2_lane1", bus.fu_resp[1], 0);
    check("t2_count", bus.count, 1);

    // Fill to 7, then retire two while blocked.
    for (int i = 0; i < 3; i++) begin
      push2(16'h8010 + 16'(2 * i));
      step();
    end
    idle();
    check("t3_count7", bus.count, 7);
    check("t3_notready", bus.enq_ready, 0);
    bus.fu_claim = 2'b11;
    step(); idle();
    check("t3_count5", bus.count, 5);
    check("t3_ready", bus.enq_ready, 1);
    check("t3_head", bus.fu_resp[0].opid, 16'h8011);

    // Steady push/claim across several pointer wraps.
    rst_n = 1'b0; step(); rst_n = 1'b1;
    push2(16'h8100);
    step();
    for (int i = 0; i < 20; i++) begin
      push2(16'h8102 + 16'(2 * i));
      bus.fu_claim = 2'b11;
      step();
      check("t4_count", bus.count, 2);
      check("t4_order", bus.fu_resp[0].opid, 16'h8100 + 16'(2 * (i + 1)));
    end
    idle();

    // Non-prefix claim retires nothing.
    bus.fu_claim = 2'b10;
    step(); idle();
    check("t5_count", bus.count, 2);
    check("t5_head", bus.fu_resp[0].opid, 16'h8128);

    // Flush beats same-cycle enqueue and claim.
    for (int i = 0; i < 2; i++) begin
      push2(16'h8200 + 16'(2 * i));
      step();
    end
    push2(16'h8210);
    bus.fu_claim = 2'b11;
    bus.flush    = 1'b1;
    check("t6_preflush_count", bus.count, 6);
    step(); idle();
    check("t6_count", bus.count, 0);
    check("t6_vld", {bus.fu_resp[1].opid[OPID_VLD], bus.fu_resp[0].opid[OPID_VLD]}, 0);
    check("t6_ready", bus.enq_ready, 1);

    // Reset mid-stream behaves like flush.
    for (int i = 0; i < 2; i++) begin
      push2(16'h8300 + 16'(2 * i));
      step();
    end
    push2(16'h8310);
    bus.fu_claim = 2'b11;
    rst_n = 1'b0;
    step(); idle();
    rst_n = 1'b1;
    check("t6r_count", bus.count, 0);
    check("t6r_vld", {bus.fu_resp[1].opid[OPID_VLD], bus.fu_resp[0].opid[OPID_VLD]}, 0);

    // Random legal traffic with occasional flush and reset.
    for (int c = 0; c < 600; c++) begin
      logic [1:0] vmask;
      int         len;
      vmask = ((DEPTH - mq.size()) >= EWD) ? 2'($urandom_range(0, 3)) : 2'b00;
      for (int j = 0; j < EWD; j++) begin
        bus.enq[j].opid   = {vmask[j], 15'($urandom)};
        bus.enq[j].result = $urandom;
        bus.enq[j].rd     = 5'($urandom);
        bus.enq[j].exc    = 1'($urandom);
      end
      len          = $urandom_range(0, 2);
      bus.fu_claim = 2'((1 << len) - 1);
      bus.flush    = ($urandom_range(0, 31) == 0);
      rst_n        = ($urandom_range(0, 63) != 0);
      step();
    end
    idle();
    rst_n = 1'b1;
    repeat (2) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
